perm_cost_feeder: RTL and testbench

- Producer side of the cost-calculator handshake.
- Walks every job permutation of N workers in lexicographic order, starting at identity.
- For each worker it requests the (W, J) entry from the cost ROM, captures the returned Cost, and hands it to the cost calculator with a one-cycle start pulse.
- It then waits for the calculator's done before moving to the next worker.
- Sits between the cost ROM and the min-cost/match-count accumulator in the job-assignment datapath.

---
 rtl/perm_cost_feeder_if.sv | 24 ++
 rtl/perm_cost_feeder.sv | 135 +++++++++++++
 tb/tb_perm_cost_feeder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/perm_cost_feeder_if.sv
// Cost ROM request/response and cost-calculator handshake between the feeder and its neighbours.
// start is a one-cycle valid for Cost; done is the calculator's level acknowledge, honoured only while waiting.
interface perm_cost_feeder_if #(
  parameter int IW = 3,
  parameter int CW = 7
) ();
  logic [IW-1:0] W;
  logic [IW-1:0] J;
  logic [CW-1:0] Cost_in;
  logic [CW-1:0] Cost;
  logic          start;
  logic          perm_last;
  logic          done;

  modport master (
    output W, J, Cost, start, perm_last,
    input  Cost_in, done
  );

  modport slave (
    input  W, J, Cost, start, perm_last,
    output Cost_in, done
  );
endinterface

// File: rtl/perm_cost_feeder.sv
// Walks all job permutations in lexicographic order and feeds each (worker, job) cost to the calculator.
// state_dbg exposes the FSM state in declaration order (IDLE = 0 ... FINISH = 9).
module perm_cost_feeder #(
  parameter int N   = 8,
  parameter int IW  = 3,
  parameter int CW  = 7,
  parameter int PCW = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                go,
  perm_cost_feeder_if.master  bus,
  output logic [PCW-1:0]      perm_cnt,
  output logic                busy,
  output logic                all_done,
  output logic [3:0]          state_dbg
);

  typedef enum logic [3:0] {
    IDLE, REQ, ROM, SEND, WAIT_DONE, PIVOT, SUCC, SWAP, REV, FINISH
  } state_t;

  localparam logic [IW-1:0] LAST      = IW'(N - 1);
  localparam logic [IW-1:0] FIRST_PIV = IW'(N - 2);

  state_t        state, nxt;
  logic [IW-1:0] perm [N];
  logic [IW-1:0] w_q;
  logic [IW-1:0] pi, pk, lo, hi;
  logic [IW-1:0] pi1;
  logic [CW-1:0] cost_q;

  assign pi1 = pi + IW'(1);

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (go) nxt = REQ;
      REQ:       nxt = ROM;
      ROM:       nxt = SEND;
      SEND:      nxt = WAIT_DONE;
      WAIT_DONE: if (bus.done) nxt = (w_q == LAST) ? PIVOT : REQ;
      PIVOT: begin
        if (perm[pi] < perm[pi1]) nxt = SUCC;
        else if (pi == '0)        nxt = FINISH;
      end
      SUCC:      if (perm[pk] > perm[pi]) nxt = SWAP;
      SWAP:      nxt = REV;
      REV:       if (lo >= hi) nxt = REQ;
      FINISH:    nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < N; i++) perm[i] <= IW'(i);
      w_q      <= '0;
      pi       <= '0;
      pk       <= '0;
      lo       <= '0;
      hi       <= '0;
      cost_q   <= '0;
      perm_cnt <= '0;
      busy     <= 1'b0;
      all_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            for (int i = 0; i < N; i++) perm[i] <= IW'(i);
            w_q      <= '0;
            perm_cnt <= '0;
            busy     <= 1'b1;
            all_done <= 1'b0;
          end
        end
        ROM: cost_q <= bus.Cost_in;
        WAIT_DONE: begin
          if (bus.done) begin
            if (w_q == LAST) begin
              perm_cnt <= perm_cnt + PCW'(1);
              pi       <= FIRST_PIV;
            end else begin
              w_q <= w_q + IW'(1);
            end
          end
        end
        PIVOT: begin
          // Pivot found: successor scan starts from the right end.
          if (perm[pi] < perm[pi1]) pk <= LAST;
          else if (pi != '0)        pi <= pi - IW'(1);
        end
        SUCC: begin
          if (!(perm[pk] > perm[pi])) pk <= pk - IW'(1);
        end
        SWAP: begin
          perm[pi] <= perm[pk];
          perm[pk] <= perm[pi];
          lo       <= pi1;
          hi       <= LAST;
        end
        REV: begin
          if (lo < hi) begin
            perm[lo] <= perm[hi];
            perm[hi] <= perm[lo];
            lo       <= lo + IW'(1);
            hi       <= hi - IW'(1);
          end else begin
            w_q <= '0;
          end
        end
        FINISH: begin
          busy     <= 1'b0;
          all_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // J follows perm[W]; both are untouched from REQ through WAIT_DONE.
  assign bus.W         = w_q;
  assign bus.J         = perm[w_q];
  assign bus.Cost      = cost_q;
  assign bus.start     = (state == SEND);
  assign bus.perm_last = (state == SEND) && (w_q == LAST);
  assign state_dbg     = state;

endmodule

// File: tb/tb_perm_cost_feeder.sv
// Randomized bench for perm_cost_feeder: a ROM model, a calculator model with random done delay,
// and a scoreboard filled from a rank-to-permutation reference.
module tb_perm_cost_feeder;
  localparam int N   = 5;
  localparam int IW  = 3;
  localparam int CW  = 7;
  localparam int PCW = 16;
  localparam int XW  = 1 + 2 * IW + CW;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           go  = 1'b0;
  logic [PCW-1:0] perm_cnt;
  logic           busy;
  logic           all_done;
  logic [3:0]     state_dbg;

  perm_cost_feeder_if #(.IW(IW), .CW(CW)) bus ();

  perm_cost_feeder #(.N(N), .IW(IW), .CW(CW), .PCW(PCW)) dut (
    .CLK(clk), .RST(rst), .go(go), .bus(bus),
    .perm_cnt(perm_cnt), .busy(busy), .all_done(all_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- reference data ----------------
  logic [CW-1:0] rom [N][N];
  logic [XW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_starts = 0;
  int            n_lasts  = 0;
  int            n_alldone = 0;
  logic          ad_prev  = 1'b0;
  logic [CW-1:0] last_w0_cost;
  bit            mon_en = 1'b0;

  function automatic int fact(input int k);
    int f = 1;
    for (int i = 2; i <= k; i++) f = f * i;
    return f;
  endfunction

  localparam int NF = 120;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic load_rom(input bit random_fill);
    for (int w = 0; w < N; w++)
      for (int j = 0; j < N; j++)
        rom[w][j] = random_fill ? CW'($urandom_range(0, 127)) : CW'(w * 8 + j);
  endtask

  // Permutation of a given lexicographic rank via the factorial number system.
  task automatic fill_exp();
    int f, r, idx;
    int avail [$];
    logic [IW-1:0] p [N];
    exp_q.delete();
    for (int rank = 0; rank < NF; rank++) begin
      avail.delete();
      for (int v = 0; v < N; v++) avail.push_back(v);
      r = rank;
      for (int pos = 0; pos < N; pos++) begin
        f   = fact(N - 1 - pos);
        idx = r / f;
        r   = r % f;
        p[pos] = IW'(avail[idx]);
        avail.delete(idx);
      end
      for (int w = 0; w < N; w++)
        exp_q.push_back({(w == N - 1), IW'(w), p[w], rom[w][p[w]]});
    end
  endtask

  // ---------------- ROM model: one-cycle read latency ----------------
  always @(posedge clk) bus.Cost_in <= rom[bus.W][bus.J];

  // ---------------- calculator model + scoreboard ----------------
  initial begin
    bit                    pending = 1'b0;
    bit                    issued  = 1'b0;
    int                    cnt     = 0;
    logic [2*IW+CW-1:0]    hold    = '0;
    logic [XW-1:0]         e;
    bus.done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (all_done && !ad_prev) n_alldone++;
      ad_prev = all_done;
      if (!mon_en) begin
        pending  = 1'b0;
        issued   = 1'b0;
        bus.done = 1'b0;
      end else if (bus.start) begin
        check("start_while_pending", {31'd0, pending}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_start", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("xfer", {18'd0, bus.perm_last, bus.W, bus.J, bus.Cost}, {18'd0, e});
        end
        n_starts++;
        if (bus.perm_last) n_lasts++;
        if (bus.W == '0) last_w0_cost = bus.Cost;
        hold     = {bus.W, bus.J, bus.Cost};
        pending  = 1'b1;
        issued   = 1'b0;
        cnt      = $urandom_range(0, 7);
        // Sometimes raise done already during SEND; it must be ignored.
        bus.done = ($urandom_range(0, 3) == 0);
      end else if (pending) begin
        if (issued) begin
          pending  = 1'b0;
          issued   = 1'b0;
          bus.done = 1'b0;
        end else begin
          check("hold", {19'd0, bus.W, bus.J, bus.Cost}, {19'd0, hold});
          if (cnt == 0) begin
            bus.done = 1'b1;
            issued   = 1'b1;
          end else begin
            cnt--;
            bus.done = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_W"},        {29'd0, bus.W}, 32'd0);
    check({tag, "_J"},        {29'd0, bus.J}, 32'd0);
    check({tag, "_Cost"},     {25'd0, bus.Cost}, 32'd0);
    check({tag, "_start"},    {31'd0, bus.start}, 32'd0);
    check({tag, "_last"},     {31'd0, bus.perm_last}, 32'd0);
    check({tag, "_perm_cnt"}, {16'd0, perm_cnt}, 32'd0);
    check({tag, "_busy"},     {31'd0, busy}, 32'd0);
    check({tag, "_all_done"}, {31'd0, all_done}, 32'd0);
    check({tag, "_state"},    {28'd0, state_dbg}, 32'd0);
  endtask

  task automatic start_run();
    n_starts = 0;
    n_lasts  = 0;
    fill_exp();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("go_busy",     {31'd0, busy}, 32'd1);
    check("go_all_done", {31'd0, all_done}, 32'd0);
    check("go_cnt",      {16'd0, perm_cnt}, 32'd0);
    check("req_W",       {29'd0, bus.W}, 32'd0);
    check("req_J",       {29'd0, bus.J}, 32'd0);
    check("req_start",   {31'd0, bus.start}, 32'd0);
    @(negedge clk);
    check("rom_start",   {31'd0, bus.start}, 32'd0);
    @(negedge clk);
    check("first_start", {31'd0, bus.start}, 32'd1);
    check("first_cost",  {25'd0, bus.Cost}, {25'd0, rom[0][0]});
  endtask

  // Runs to completion with random go pulses while busy; those must not restart anything.
  task automatic finish_run(input int alldone_before);
    int cyc = 0;
    while (!all_done && cyc < 30000) begin
      @(negedge clk);
      go = busy && ($urandom_range(0, 7) == 0);
      cyc++;
    end
    go = 1'b0;
    check("run_timeout",   {31'd0, all_done}, 32'd1);
    @(negedge clk);
    check("end_busy",      {31'd0, busy}, 32'd0);
    check("end_all_done",  {31'd0, all_done}, 32'd1);
    check("end_perm_cnt",  {16'd0, perm_cnt}, NF);
    check("end_exp_empty", exp_q.size(), 32'd0);
    check("end_starts",    n_starts, NF * N);
    check("end_lasts",     n_lasts, NF);
    check("end_last_w0",   {25'd0, last_w0_cost}, {25'd0, rom[0][N-1]});
    check("alldone_edges", n_alldone, alldone_before + 1);
    repeat (3) @(negedge clk);
    check("alldone_held",  {31'd0, all_done}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    load_rom(1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("rst");
    rst    = 1'b1;
    mon_en = 1'b1;

    start_run();
    finish_run(0);

    load_rom(1'b1);
    start_run();
    finish_run(1);

    // Reset in the middle of permutation 100's successor computation.
    load_rom(1'b1);
    start_run();
    cyc = 0;
    while (perm_cnt != PCW'(100) && cyc < 30000) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_100", {16'd0, perm_cnt}, 32'd100);
    repeat ($urandom_range(1, 6)) @(negedge clk);
    mon_en = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    exp_q.delete();
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("post_rst_cnt", {16'd0, perm_cnt}, 32'd0);
    n_alldone = 0;
    start_run();
    finish_run(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
